// File: rtl/pcap_pkg.sv
// rtl/pcap_pkg.sv - shared types and constants for the pcap replay arbiter
package pcap_pkg;

  localparam int PCAP_BYTE_W = 8;
  localparam int PCAP_NSRC   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin chooser
module rr_pick2
  import pcap_pkg::*;
(
  input  logic [PCAP_NSRC-1:0] req,
  input  logic                 last,
  output logic [PCAP_NSRC-1:0] grant,
  output logic                 gnt_idx
);

  // On contention the source that did not win last time takes the grant.
  always_comb begin
    gnt_idx = (req == 2'b11) ? ~last : req[1];
    grant   = 2'b00;
    if (req != 2'b00) begin
      grant = gnt_idx ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/pcap_replay_arbiter.sv
// rtl/pcap_replay_arbiter.sv - packet-boundary round-robin mux of two pcap replay sources
module pcap_replay_arbiter
  import pcap_pkg::*;
#(
  parameter int GAP_CYCLES = 12
) (
  input  logic                             CLOCK,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [PCAP_NSRC-1:0]             src_available,
  input  logic [PCAP_NSRC-1:0]             src_datavalid,
  input  logic [PCAP_NSRC*PCAP_BYTE_W-1:0] src_data,
  input  logic [PCAP_NSRC-1:0]             src_finished,
  output logic [PCAP_NSRC-1:0]             src_pause,
  output logic                             out_valid,
  output logic [PCAP_BYTE_W-1:0]           out_data,
  output logic                             out_sop,
  output logic                             out_eop,
  output logic                             out_src,
  output logic [7:0]                       pkt_count0,
  output logic [7:0]                       pkt_count1,
  output logic                             all_done
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  arb_state_t                 state_q;
  logic                       last_q;
  logic                       sop_pending_q;
  logic [GAP_W-1:0]           gap_q;
  logic [PCAP_NSRC-1:0]       src_pause_q;
  logic                       out_valid_q;
  logic [PCAP_BYTE_W-1:0]     out_data_q;
  logic                       out_sop_q;
  logic                       out_eop_q;
  logic                       out_src_q;
  logic [7:0]                 pkt_count0_q;
  logic [7:0]                 pkt_count1_q;
  logic                       all_done_q;

  logic [PCAP_NSRC-1:0]       req;
  logic [PCAP_NSRC-1:0]       pick_grant;
  logic                       pick_idx;
  logic                       g_valid;
  logic [PCAP_BYTE_W-1:0]     g_data;
  logic                       pkt_end;

  assign req = src_available & ~src_finished;

  rr_pick2 u_pick (
    .req     (req),
    .last    (last_q),
    .grant   (pick_grant),
    .gnt_idx (pick_idx)
  );

  // out_src_q always names the granted source while in GRANT/DRAIN.
  assign g_valid = src_datavalid[out_src_q];
  assign g_data  = src_data[{out_src_q, 3'b000} +: PCAP_BYTE_W];
  assign pkt_end = ~src_available[out_src_q] | src_finished[out_src_q];

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      sop_pending_q <= 1'b0;
      gap_q         <= '0;
      src_pause_q   <= 2'b11;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      out_src_q     <= 1'b0;
      pkt_count0_q  <= '0;
      pkt_count1_q  <= '0;
      all_done_q    <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      all_done_q  <= (&src_finished) && (state_q == IDLE);

      case (state_q)
        IDLE: begin
          if (enable && (req != 2'b00)) begin
            out_src_q     <= pick_idx;
            src_pause_q   <= ~pick_grant;
            sop_pending_q <= 1'b1;
            state_q       <= GRANT;
          end
        end

        GRANT: begin
          out_valid_q <= g_valid;
          out_sop_q   <= g_valid & sop_pending_q;
          if (g_valid) begin
            out_data_q    <= g_data;
            sop_pending_q <= 1'b0;
          end
          if (pkt_end) begin
            src_pause_q <= 2'b11;
            state_q     <= DRAIN;
          end
        end

        // Absorbs the byte a source may still emit while its pause propagates.
        DRAIN: begin
          out_valid_q <= g_valid;
          out_sop_q   <= g_valid & sop_pending_q;
          if (g_valid) begin
            out_data_q <= g_data;
          end
          sop_pending_q <= 1'b0;
          out_eop_q     <= 1'b1;
          if (out_src_q) begin
            pkt_count1_q <= pkt_count1_q + 8'd1;
          end else begin
            pkt_count0_q <= pkt_count0_q + 8'd1;
          end
          gap_q   <= GAP_LOAD;
          last_q  <= out_src_q;
          state_q <= GAP;
        end

        GAP: begin
          if (gap_q == '0) begin
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign src_pause  = src_pause_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sop    = out_sop_q;
  assign out_eop    = out_eop_q;
  assign out_src    = out_src_q;
  assign pkt_count0 = pkt_count0_q;
  assign pkt_count1 = pkt_count1_q;
  assign all_done   = all_done_q;

endmodule

// File: tb/tb_pcap_replay_arbiter.sv
// tb/tb_pcap_replay_arbiter.sv - directed self-checking bench for pcap_replay_arbiter
module tb_pcap_replay_arbiter;

  logic        CLOCK = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  src_available;
  logic [1:0]  src_datavalid;
  logic [15:0] src_data;
  logic [1:0]  src_finished;
  logic [1:0]  src_pause;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sop;
  logic        out_eop;
  logic        out_src;
  logic [7:0]  pkt_count0;
  logic [7:0]  pkt_count1;
  logic        all_done;

  int checks = 0;
  int errors = 0;

  pcap_replay_arbiter #(.GAP_CYCLES(12)) dut (
    .CLOCK         (CLOCK),
    .reset         (reset),
    .enable        (enable),
    .src_available (src_available),
    .src_datavalid (src_datavalid),
    .src_data      (src_data),
    .src_finished  (src_finished),
    .src_pause     (src_pause),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_sop       (out_sop),
    .out_eop       (out_eop),
    .out_src       (out_src),
    .pkt_count0    (pkt_count0),
    .pkt_count1    (pkt_count1),
    .all_done      (all_done)
  );

  always #5 CLOCK = ~CLOCK;

  // Output monitor: collects the forwarded stream and packet framing events.
  int         cyc = 0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  logic [8:0] sop_q[$];
  int         gaps[$];
  int         eop_n = 0;
  int         eop_dist = 0;
  int         p1_low_n = 0;
  int         last_valid_cyc = 0;

  always @(posedge CLOCK) cyc <= cyc + 1;

  always @(negedge CLOCK) begin
    if (!reset) begin
      if (out_sop) begin
        sop_q.push_back({out_src, out_data});
        gaps.push_back(cyc - last_valid_cyc);
      end
      if (out_eop) begin
        eop_n    = eop_n + 1;
        eop_dist = cyc - last_valid_cyc;
      end
      if (out_valid) begin
        got_q.push_back({out_src, out_data});
        last_valid_cyc = cyc;
      end
      if (!src_pause[1]) p1_low_n = p1_low_n + 1;
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(input int s, output bit ok);
    int t;
    t = 0;
    while (src_pause[s] !== 1'b0 && t < 300) begin
      step();
      t++;
    end
    ok = (t < 300);
    check("grant_wait", {31'd0, ok}, 32'd1);
  endtask

  // Source model: drives len bytes once granted, available drops with the last byte.
  task automatic send_pkt(input int s, input int len, input logic [7:0] base,
                          input bit extra, input bit keep_avail, input bit junk);
    bit ok;
    int o;
    o = 1 - s;
    src_available[s] = 1'b1;
    wait_grant(s, ok);
    if (!ok) return;
    for (int i = 0; i < len; i++) begin
      src_datavalid[s]      = 1'b1;
      src_data[8*s +: 8]    = base + 8'(i);
      src_available[s]      = (i != len - 1);
      if (junk) begin
        src_datavalid[o]   = 1'b1;
        src_data[8*o +: 8] = 8'hEE;
      end
      exp_q.push_back({s[0], base + 8'(i)});
      step();
    end
    src_datavalid = 2'b00;
    if (extra) begin
      src_datavalid[s]   = 1'b1;
      src_data[8*s +: 8] = base + 8'(len);
      exp_q.push_back({s[0], base + 8'(len)});
      step();
      src_datavalid = 2'b00;
    end
    src_available[s] = keep_avail;
  endtask

  task automatic cmp_stream(input string tag, input int g0, input int e0);
    int n_got;
    int n_exp;
    int bad;
    n_got = got_q.size() - g0;
    n_exp = exp_q.size() - e0;
    bad   = 0;
    check({tag, "_len"}, n_got, n_exp);
    for (int k = 0; k < n_exp && k < n_got; k++) begin
      if (got_q[g0 + k] !== exp_q[e0 + k]) bad++;
    end
    check({tag, "_data"}, bad, 0);
  endtask

  initial begin
    int  g0, e0, s0, p1, en, gp0;
    bit  ok;

    reset         = 1'b1;
    enable        = 1'b1;
    src_available = 2'b00;
    src_datavalid = 2'b00;
    src_data      = 16'h0000;
    src_finished  = 2'b00;
    step(3);
    check("rst_pause", src_pause, 2'b11);
    check("rst_valid", out_valid, 0);
    check("rst_sop", out_sop, 0);
    check("rst_eop", out_eop, 0);
    check("rst_data", out_data, 0);
    check("rst_src", out_src, 0);
    check("rst_cnt0", pkt_count0, 0);
    check("rst_cnt1", pkt_count1, 0);
    check("rst_done", all_done, 0);
    reset = 1'b0;
    step();

    // Single 60-byte packet from source 0.
    g0 = got_q.size(); e0 = exp_q.size(); s0 = sop_q.size(); p1 = p1_low_n; en = eop_n;
    send_pkt(0, 60, 8'h10, 1'b0, 1'b0, 1'b0);
    step(20);
    cmp_stream("t1", g0, e0);
    check("t1_sop_n", sop_q.size() - s0, 1);
    if (sop_q.size() > s0) check("t1_sop_byte", sop_q[s0], {1'b0, 8'h10});
    check("t1_eop_n", eop_n - en, 1);
    check("t1_eop_dist", eop_dist, 1);
    check("t1_cnt0", pkt_count0, 1);
    check("t1_pause1", p1_low_n - p1, 0);

    // Extra byte during the pause-latency cycle.
    g0 = got_q.size(); e0 = exp_q.size(); en = eop_n;
    send_pkt(0, 8, 8'h80, 1'b1, 1'b0, 1'b0);
    step(20);
    cmp_stream("t3", g0, e0);
    check("t3_eop_n", eop_n - en, 1);
    check("t3_cnt0", pkt_count0, 2);

    // Reset mid-packet on source 1 at byte 20.
    src_available[1] = 1'b1;
    wait_grant(1, ok);
    for (int i = 0; i < 20; i++) begin
      src_datavalid[1] = 1'b1;
      src_data[15:8]   = 8'h40 + 8'(i);
      step();
    end
    check("t4_src_before", out_src, 1);
    en = eop_n;
    src_data[15:8] = 8'h54;
    reset = 1'b1;
    step();
    check("t4_pause", src_pause, 2'b11);
    check("t4_valid", out_valid, 0);
    check("t4_eop", out_eop, 0);
    check("t4_src", out_src, 0);
    check("t4_data", out_data, 0);
    check("t4_cnt0", pkt_count0, 0);
    check("t4_cnt1", pkt_count1, 0);
    reset         = 1'b0;
    src_datavalid = 2'b00;
    src_available = 2'b00;
    step(20);
    check("t4_no_eop", eop_n - en, 0);
    check("t4_pause_idle", src_pause, 2'b11);

    // Both sources continuously available, paused source streams junk.
    g0 = got_q.size(); e0 = exp_q.size(); s0 = sop_q.size(); gp0 = gaps.size();
    src_available = 2'b11;
    for (int p = 0; p < 6; p++) begin
      send_pkt(p % 2, 10 + p, 8'h20 + 8'(16 * p), 1'b0, 1'b1, 1'b1);
    end
    src_available = 2'b00;
    step(30);
    cmp_stream("t2", g0, e0);
    check("t2_sop_n", sop_q.size() - s0, 6);
    for (int k = 0; k < 6 && s0 + k < sop_q.size(); k++) begin
      check("t2_order", sop_q[s0 + k][8], k % 2);
    end
    for (int k = 1; k < 6 && gp0 + k < gaps.size(); k++) begin
      check("t2_gap_min", (gaps[gp0 + k] >= 14), 1);
    end
    check("t2_cnt0", pkt_count0, 3);
    check("t2_cnt1", pkt_count1, 3);

    // Enable gating.
    enable        = 1'b0;
    src_available = 2'b10;
    step(30);
    check("t6_no_grant", src_pause, 2'b11);
    enable = 1'b1;
    step();
    check("t6_grant_lat", src_pause, 2'b01);
    g0 = got_q.size(); e0 = exp_q.size();
    send_pkt(1, 5, 8'hC0, 1'b0, 1'b0, 1'b0);
    step(20);
    cmp_stream("t6", g0, e0);
    check("t6_cnt1", pkt_count1, 4);

    // Zero-byte packet.
    s0 = sop_q.size(); en = eop_n;
    src_available[0] = 1'b1;
    wait_grant(0, ok);
    src_available[0] = 1'b0;
    step(20);
    check("t7_sop_n", sop_q.size() - s0, 0);
    check("t7_eop_n", eop_n - en, 1);
    check("t7_cnt0", pkt_count0, 4);

    // Counter wrap and completion.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    for (int k = 0; k < 255; k++) begin
      send_pkt(0, 1, 8'(k), 1'b0, 1'b0, 1'b0);
    end
    step(5);
    check("t5_cnt0_255", pkt_count0, 255);
    send_pkt(0, 1, 8'hFF, 1'b0, 1'b0, 1'b0);
    step(5);
    check("t5_cnt0_wrap", pkt_count0, 0);
    check("t5_cnt1", pkt_count1, 0);
    step(20);
    check("t5_done_pre", all_done, 0);
    src_finished = 2'b11;
    step();
    check("t5_done", all_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
